// File: rtl/if_prefetch.sv
// Instruction-fetch initiator with a small prefetch FIFO in front of the IF/ID boundary.
// Branch redirects honour one MIPS delay slot.
module if_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [63:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc;
  logic          rom_ce;

  logic valid;
  logic full;
  logic pop;
  logic fetch;
  logic redirect;
  logic flush;
  logic push;
  logic [63:0] head;

  always_comb begin
    valid    = (count != '0);
    full     = count[PW];
    pop      = valid & ~stall;
    fetch    = rom_ce & (~full | pop);
    redirect = branch_flag_i & ~stall & ~rst;
    // A redirect with a non-empty FIFO pops the delay slot and drops everything
    // else, including this cycle's fetch; with an empty FIFO the fetch is the slot.
    flush    = redirect & valid;
    push     = fetch & ~flush & ~rst;
    head     = fifo_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rom_ce   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      rom_ce <= 1'b1;
      if (redirect) begin
        fetch_pc <= branch_target_address_i;
      end else if (fetch) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {fetch_pc, rom_inst_i};
    end
  end

  always_comb begin
    rom_ce_o   = rom_ce;
    rom_addr_o = fetch_pc;
    if_valid_o = valid;
    if_pc_o    = valid ? head[63:32] : '0;
    if_inst_o  = valid ? head[31:0]  : '0;
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Instruction-fetch initiator: drives the chip-enable and byte-address port of the combinational instruction memory and captures the returned word.
- Buffers fetched words in a small prefetch FIFO so that fetch continues while decode is stalled.
- Presents the oldest word to the IF/ID boundary.
- Handles branch redirects with one MIPS delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode not accepting; 1 = hold the FIFO head.
- branch_flag_i  in  1  redirect request from ID; sampled only when stall=0.
- branch_target_address_i  in  32  redirect byte address; word aligned.
- rom_ce_o  out  1  instruction memory enable, registered.
- rom_addr_o  out  32  fetch byte address, equal to fetch_pc.
- rom_inst_i  in  32  instruction word; valid in the same cycle as rom_addr_o.
- if_pc_o  out  32  byte address of the FIFO head.
- if_inst_o  out  32  instruction at the FIFO head.
- if_valid_o  out  1  FIFO is non-empty.

Behaviour:
- Reset (rst=1 at a clock edge, including mid-operation):
  - fetch_pc <= RESET_PC.
  - FIFO emptied: read and write pointers and count go to 0.
  - rom_ce_o <= 0.
  - Outputs while the FIFO is empty: if_valid_o=0, if_pc_o=0, if_inst_o=0.
  - A branch request in the reset cycle is ignored.
- rom_ce_o <= 1 on the first edge with rst=0 and stays 1 until the next reset. When rom_ce_o=0 nothing is fetched.
- Signal definitions:
  - pop = if_valid_o & ~stall.
  - fetch = rom_ce_o & (count < FIFO_DEPTH, or pop).
  - The FIFO accepts a push and a pop in the same cycle when full.
- Normal cycle, no redirect:
  - If fetch: push {fetch_pc, rom_inst_i} and set fetch_pc <= fetch_pc + 4. The add wraps modulo 2^32.
  - If pop: the head advances.
  - count changes by push minus pop.
  - If fetch is 0, fetch_pc holds.
- Redirect: branch_flag_i=1 while stall=0 and rst=0. The instruction in ID is the branch; the next sequential word is its delay slot.
  - FIFO non-empty: the head is the delay slot and is popped this cycle. All remaining entries are discarded and this cycle's fetch is not written. The FIFO is empty next cycle.
  - FIFO empty: this cycle's fetch, at address fetch_pc, is the delay slot. It is pushed if rom_ce_o=1, and the FIFO holds exactly that entry next cycle.
  - In both cases fetch_pc <= branch_target_address_i.
  - branch_flag_i with stall=1 has no effect; ID reasserts it once the stall clears.
- FIFO storage and pointers:
  - Stored entries are 64 bits wide: a 32-bit PC and a 32-bit instruction.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
  - count is log2(FIFO_DEPTH)+1 bits wide.
  - The head is a combinational read of the storage.
- Latency:
  - Address to FIFO entry: 1 cycle.
  - Empty FIFO to if_valid_o: 1 cycle after the fetch edge.
  - Reset release to first if_valid_o: 2 cycles (enable cycle, then fetch cycle).
- Steady streaming (stall=0): one instruction per cycle with no bubbles. The FIFO occupancy stays at 1.
- Full with stall=1: fetch_pc and all entries hold, and no fetches are issued. rom_ce_o stays 1; the memory is combinational, so no side effects.
- Misaligned branch targets are passed through unchanged, with no trap. The memory ignores address bits [1:0].

Test Plan:
- Reset and start: hold rst for 3 cycles, then release. Required response:
  - rom_ce_o=0 during reset, then 1.
  - rom_addr_o sequence 0, 4, 8, and so on.
  - if_valid_o first rises 2 cycles after release, with if_pc_o=0 and if_inst_o=mem[0].
  - Consecutive pops yield PC 0, 4, 8, 12 with the matching words.
- Stall fill: stall=1 from the first valid cycle. Required response:
  - count reaches 4 after 4 fetches (PCs 0 to 12); rom_addr_o then holds at 16 and if_pc_o holds at 0.
  - After releasing the stall, the consumer sees 0, 4, 8, 12, 16, 20 with no gaps and no duplicates.
- Branch with a non-empty FIFO: head PC 0x20 in a stalled, full FIFO (entries 0x20 to 0x2C); release stall and pulse branch_flag_i with target 0x100 in the same cycle. Required response:
  - 0x20 is consumed this cycle.
  - if_valid_o=0 next cycle.
  - The next delivered PCs are 0x100, 0x104.
  - 0x24 to 0x2C are never delivered.
- Branch with an empty FIFO: stall=0 streaming, then branch_flag_i while the FIFO is empty and rom_addr_o=0x40, target 0x200. Required response:
  - Next delivered PC is 0x40 (the delay slot), then 0x200, 0x204.
- Branch while stalled: branch_flag_i=1 with stall=1 and target 0x300. Required response: no change to fetch_pc or FIFO contents.
- Reset mid-operation: rst=1 with 3 entries in the FIFO and fetch_pc=0x80. Required response:
  - Next cycle: if_valid_o=0, rom_ce_o=0, rom_addr_o=RESET_PC.
  - After release, delivery restarts at PC 0.
  - A pointer-wrap check, run with 10 or more fetches under random stall, sees no entry lost or duplicated.
